// File: rtl/cntr_div_bank.sv
// cntr_div_bank: bank of NCH wrap/saturate counters with per-channel output
// bypass mux, plus a programmable clock divider with glitch-free ratio
// changes and a pulse-aligned gated copy of the divided clock.
module cntr_div_bank #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned NCH      = 3,
  parameter int unsigned DIVW     = 8,
  parameter int unsigned DIV_INIT = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NCH-1:0]       EN_CNT,
  input  logic [NCH-1:0]       CLR_CNT,
  input  logic [NCH-1:0]       SAT_MODE,
  input  logic [NCH-1:0]       SELECT,
  input  logic [NCH*WIDTH-1:0] BYPASS,
  output logic [NCH*WIDTH-1:0] CNTR_OUT,
  output logic [NCH-1:0]       WRAP,
  input  logic [DIVW-1:0]      DIV_RATIO,
  input  logic                 DIV_LOAD,
  output logic                 DIV_BUSY,
  input  logic                 EN_G,
  output logic                 CLK_OUT_DIV,
  output logic                 CLK_OUT_G
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } div_state_t;

  // ---------------------------------------------------------------------
  // Counter channels
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;

    // Next count: clear beats enable; at max either wrap (with pulse) or stick.
    always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (CLR_CNT[g]) begin
        cnt_d = '0;
      end else if (EN_CNT[g]) begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + WIDTH'(1);
        end else if (!SAT_MODE[g]) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end
      end
    end

    // Counter and wrap-pulse registers.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        cnt_q  <= '0;
        wrap_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        wrap_q <= wrap_d;
      end
    end

    assign CNTR_OUT[g*WIDTH +: WIDTH] = SELECT[g] ? cnt_q : BYPASS[g*WIDTH +: WIDTH];
    assign WRAP[g]                    = wrap_q;
  end

  // ---------------------------------------------------------------------
  // Clock divider
  // ---------------------------------------------------------------------
  div_state_t      state_q, state_d;
  logic [DIVW-1:0] ratio_q, ratio_d;
  logic [DIVW-1:0] dcnt_q, dcnt_d;
  logic [DIVW-1:0] pval_q, pval_d;
  logic            pend_q, pend_d;
  logic            div_q, div_d;
  logic            gate_q, gate_d;
  logic            clkg_q;

  // Divider next-state: a pending ratio is only taken at the falling toggle
  // so every period completes; the gate flag follows EN_G only at a rise.
  always_comb begin
    state_d = state_q;
    ratio_d = ratio_q;
    dcnt_d  = dcnt_q;
    pval_d  = pval_q;
    pend_d  = pend_q;
    div_d   = div_q;
    gate_d  = gate_q;
    unique case (state_q)
      S_IDLE: begin
        dcnt_d = '0;
        div_d  = 1'b0;
        if (DIV_LOAD) begin
          ratio_d = DIV_RATIO;
          if (DIV_RATIO != '0) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (dcnt_q == ratio_q - DIVW'(1)) begin
          dcnt_d = '0;
          div_d  = ~div_q;
          if (div_q && pend_q) begin
            pend_d  = 1'b0;
            ratio_d = pval_q;
            if (pval_q == '0) state_d = S_IDLE;
          end
        end else begin
          dcnt_d = dcnt_q + DIVW'(1);
        end
        if (DIV_LOAD) begin
          pend_d = 1'b1;
          pval_d = DIV_RATIO;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (div_d && !div_q) gate_d = EN_G;
  end

  // Divider state registers; gated output registered from the next values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= (DIV_INIT != 0) ? S_RUN : S_IDLE;
      ratio_q <= DIVW'(DIV_INIT);
      dcnt_q  <= '0;
      pval_q  <= '0;
      pend_q  <= 1'b0;
      div_q   <= 1'b0;
      gate_q  <= 1'b0;
      clkg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ratio_q <= ratio_d;
      dcnt_q  <= dcnt_d;
      pval_q  <= pval_d;
      pend_q  <= pend_d;
      div_q   <= div_d;
      gate_q  <= gate_d;
      clkg_q  <= div_d & gate_d;
    end
  end

  assign DIV_BUSY    = pend_q;
  assign CLK_OUT_DIV = div_q;
  assign CLK_OUT_G   = clkg_q;

endmodule

// File: tb/tb_cntr_div_bank.sv
// tb_cntr_div_bank: directed stimulus with literal expectations plus an
// every-cycle comparison against a period/phase model of the bank.
module tb_cntr_div_bank;

  localparam int W     = 3;
  localparam int N     = 3;
  localparam int DW    = 8;
  localparam int DINIT = 1;
  localparam int NW    = N * W;
  localparam int MX    = (1 << W) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [N-1:0]  EN_CNT = '0, CLR_CNT = '0, SAT_MODE = '0, SELECT = '1;
  logic [NW-1:0] BYPASS = '0;
  logic [NW-1:0] CNTR_OUT;
  logic [N-1:0]  WRAP;
  logic [DW-1:0] DIV_RATIO = '0;
  logic          DIV_LOAD = 1'b0;
  logic          DIV_BUSY;
  logic          EN_G = 1'b0;
  logic          CLK_OUT_DIV, CLK_OUT_G;

  int checks = 0;
  int errors = 0;

  cntr_div_bank #(.WIDTH(W), .NCH(N), .DIVW(DW), .DIV_INIT(DINIT)) dut (
    .CLK(CLK), .RST(RST), .EN_CNT(EN_CNT), .CLR_CNT(CLR_CNT),
    .SAT_MODE(SAT_MODE), .SELECT(SELECT), .BYPASS(BYPASS),
    .CNTR_OUT(CNTR_OUT), .WRAP(WRAP), .DIV_RATIO(DIV_RATIO),
    .DIV_LOAD(DIV_LOAD), .DIV_BUSY(DIV_BUSY), .EN_G(EN_G),
    .CLK_OUT_DIV(CLK_OUT_DIV), .CLK_OUT_G(CLK_OUT_G)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  // Model state: counters packed like CNTR_OUT; divider as a phase position
  // inside a 2R-cycle period (low for positions 0..R-1, high for R..2R-1).
  logic [NW-1:0] m_cnt  = '0;
  logic [N-1:0]  m_wrap = '0;
  int            m_r    = DINIT;
  int            m_pos  = 0;
  bit            m_run  = (DINIT != 0);
  bit            m_clk  = 1'b0;
  bit            m_gate = 1'b0;
  bit            m_g    = 1'b0;
  bit            m_pend = 1'b0;
  int            m_pval = 0;

  // Model update on each rising edge, then compare every output 1 time unit later.
  always begin
    logic [NW-1:0] nc, exp_out;
    logic [N-1:0]  nw;
    int c, v;
    bit prev, was_run;
    @(posedge CLK);
    if (RST) begin
      m_cnt = '0; m_wrap = '0;
      m_r = DINIT; m_pos = 0; m_run = (DINIT != 0);
      m_clk = 0; m_gate = 0; m_g = 0; m_pend = 0; m_pval = 0;
    end else begin
      nc = '0;
      nw = '0;
      for (int i = 0; i < N; i++) begin
        c = int'((m_cnt >> (i * W)) & NW'(MX));
        if (((CLR_CNT >> i) & 1) != 0) begin
          c = 0;
        end else if (((EN_CNT >> i) & 1) != 0) begin
          if (!(((SAT_MODE >> i) & 1) != 0 && c == MX)) begin
            c = (c + 1) % (MX + 1);
            if (c == 0) nw = nw | N'(1 << i);
          end
        end
        nc = nc | (NW'(c) << (i * W));
      end
      m_cnt  = nc;
      m_wrap = nw;

      prev    = m_clk;
      was_run = m_run;
      if (m_run) begin
        m_pos++;
        if (m_pos == 2 * m_r) begin
          m_pos = 0;
          if (m_pend) begin
            m_pend = 0;
            m_r    = m_pval;
            if (m_r == 0) m_run = 0;
          end
        end
        m_clk = m_run && (m_pos >= m_r);
      end else begin
        m_clk = 0;
      end
      if (DIV_LOAD) begin
        if (was_run) begin
          m_pend = 1;
          m_pval = int'(DIV_RATIO);
        end else begin
          m_r   = int'(DIV_RATIO);
          m_pos = 0;
          m_clk = 0;
          m_run = (m_r != 0);
        end
      end
      if (!prev && m_clk) m_gate = EN_G;
      m_g = m_clk && m_gate;
    end
    #1;
    exp_out = '0;
    for (int i = 0; i < N; i++) begin
      if (((SELECT >> i) & 1) != 0) v = int'((m_cnt >> (i * W)) & NW'(MX));
      else                           v = int'((BYPASS >> (i * W)) & NW'(MX));
      exp_out = exp_out | (NW'(v) << (i * W));
    end
    chk("cmp_cntr_out", CNTR_OUT, exp_out);
    chk("cmp_wrap", WRAP, m_wrap);
    chk("cmp_busy", DIV_BUSY, m_pend);
    chk("cmp_clk_div", CLK_OUT_DIV, m_clk);
    chk("cmp_clk_g", CLK_OUT_G, m_g);
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    int seq_a [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    bit div_a [5]  = '{1, 0, 1, 0, 1};
    bit div_b [10] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
    bit div_c [7]  = '{0, 0, 1, 1, 0, 0, 1};
    bit gclk  [9]  = '{1, 0, 0, 1, 1, 0, 0, 1, 1};
    bit gout  [9]  = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
    logic [W-1:0] e;

    // Reset state
    step();
    chk("rst_cntr_out", CNTR_OUT, 0);
    chk("rst_wrap", WRAP, 0);
    chk("rst_busy", DIV_BUSY, 0);
    chk("rst_clk_div", CLK_OUT_DIV, 0);
    chk("rst_clk_g", CLK_OUT_G, 0);
    step();
    RST = 1'b0;
    EN_CNT = '1;
    SELECT = '1;

    // Free-running wrap: 0..7,0,1 with one wrap pulse at the 0
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      else #1;
      e = W'(seq_a[k]);
      chk("seq_cntr", CNTR_OUT, {e, e, e});
      chk("seq_wrap", WRAP, (k == 8) ? 3'b111 : 3'b000);
    end

    // Channel 1 saturates, others wrap
    SAT_MODE = 3'b010;
    repeat (6) step();
    chk("sat_at_max", CNTR_OUT, 9'o777);
    step();
    chk("sat_stick", CNTR_OUT, 9'o070);
    chk("sat_wrap", WRAP, 3'b101);
    repeat (7) step();
    chk("sat_again_max", CNTR_OUT, 9'o777);
    CLR_CNT = 3'b010;
    step();
    chk("clr_ch1_out", CNTR_OUT, 9'o000);
    chk("clr_ch1_wrap", WRAP, 3'b101);
    CLR_CNT = '0;
    repeat (7) step();
    chk("pre_clr_wrap_max", CNTR_OUT, 9'o777);
    // Clear coincident with the wrap condition on the same channel
    CLR_CNT  = 3'b001;
    SAT_MODE = '0;
    step();
    chk("clr_vs_wrap_out", CNTR_OUT, 9'o000);
    chk("clr_vs_wrap_wrap", WRAP, 3'b110);
    CLR_CNT = '0;

    // Bypass on channel 2, counter keeps running underneath
    SELECT = 3'b011;
    BYPASS = 9'o500;
    #1;
    chk("bypass_now", CNTR_OUT, 9'o500);
    repeat (2) step();
    #0;
    step();
    chk("bypass_run", CNTR_OUT, 9'o533);
    SELECT = '1;
    #1;
    chk("bypass_off", CNTR_OUT, 9'o333);
    EN_CNT = '0;
    repeat (2) step();
    chk("hold", CNTR_OUT, 9'o333);
    EN_CNT = '1;

    // Divider after reset with DIV_INIT=1: toggles every cycle
    RST = 1'b1;
    step();
    RST = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("div1_toggle", CLK_OUT_DIV, div_a[k]);
    end
    // Two loads while running: the later one (3) wins at the falling toggle
    DIV_LOAD  = 1'b1;
    DIV_RATIO = 8'd5;
    step();
    chk("ld_clk0", CLK_OUT_DIV, 0);
    chk("ld_busy0", DIV_BUSY, 1);
    DIV_RATIO = 8'd3;
    step();
    chk("ld_clk1", CLK_OUT_DIV, 1);
    chk("ld_busy1", DIV_BUSY, 1);
    DIV_LOAD = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("div3_clk", CLK_OUT_DIV, div_b[k]);
      chk("div3_busy", DIV_BUSY, 0);
    end

    // Load 0 mid high phase: high phase completes, then idle low
    DIV_LOAD  = 1'b1;
    DIV_RATIO = 8'd0;
    step();
    DIV_LOAD = 1'b0;
    chk("stop_hi0", CLK_OUT_DIV, 1);
    chk("stop_busy0", DIV_BUSY, 1);
    step();
    chk("stop_hi1", CLK_OUT_DIV, 1);
    step();
    chk("stop_lo", CLK_OUT_DIV, 0);
    chk("stop_busy_clr", DIV_BUSY, 0);
    repeat (2) step();
    chk("idle_lo", CLK_OUT_DIV, 0);

    // Load 2 from idle: first rise two cycles after the load edge
    DIV_LOAD  = 1'b1;
    DIV_RATIO = 8'd2;
    for (int k = 0; k < 7; k++) begin
      step();
      DIV_LOAD = 1'b0;
      chk("div2_clk", CLK_OUT_DIV, div_c[k]);
      chk("div2_busy", DIV_BUSY, 0);
    end

    // Gate changes mid high pulse only take effect at the next rise
    EN_G = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      chk("gate_clk", CLK_OUT_DIV, gclk[k]);
      chk("gate_out", CLK_OUT_G, gout[k]);
      if (k == 3) EN_G = 1'b0;
    end

    // Async reset mid high phase with a ratio pending: pending is discarded
    EN_G      = 1'b1;
    DIV_LOAD  = 1'b1;
    DIV_RATIO = 8'd7;
    step();
    DIV_LOAD = 1'b0;
    repeat (2) step();
    chk("pre_rst_clk", CLK_OUT_DIV, 1);
    chk("pre_rst_busy", DIV_BUSY, 1);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_cntr_out", CNTR_OUT, 0);
    chk("arst_wrap", WRAP, 0);
    chk("arst_busy", DIV_BUSY, 0);
    chk("arst_clk_div", CLK_OUT_DIV, 0);
    chk("arst_clk_g", CLK_OUT_G, 0);
    step();
    RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_clk", CLK_OUT_DIV, div_a[k]);
      chk("post_rst_busy", DIV_BUSY, 0);
    end
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
